// File: rtl/player_ctrl_grid_if.sv
// Player controller bundle: frame strobe, buttons in; position, sword, state out.
// master drives frame_tick/buttons, slave is the controller driving the outputs.
interface player_ctrl_grid_if #(
  parameter int COORD_W = 4
);
  logic               frame_tick;
  logic               btn_up;
  logic               btn_down;
  logic               btn_left;
  logic               btn_right;
  logic               btn_attack;
  logic [COORD_W-1:0] player_x;
  logic [COORD_W-1:0] player_y;
  logic [1:0]         player_dir;
  logic               player_orient;
  logic [3:0]         player_sprite;
  logic [COORD_W-1:0] sword_x;
  logic [COORD_W-1:0] sword_y;
  logic               sword_visible;
  logic [1:0]         sword_dir;
  logic [1:0]         state;

  modport master (
    output frame_tick, btn_up, btn_down, btn_left, btn_right, btn_attack,
    input  player_x, player_y, player_dir, player_orient, player_sprite,
    input  sword_x, sword_y, sword_visible, sword_dir, state
  );

  modport slave (
    input  frame_tick, btn_up, btn_down, btn_left, btn_right, btn_attack,
    output player_x, player_y, player_dir, player_orient, player_sprite,
    output sword_x, sword_y, sword_visible, sword_dir, state
  );
endinterface

// File: rtl/player_ctrl_grid.sv
// Grid player controller: movement, facing, walk animation, timed sword attack.
// Ports: clk, reset (sync, active-low), io (slave). Option: PLAYER_AUTOREPEAT_EN.
module player_ctrl_grid #(
  parameter int COORD_W         = 4,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 15,
  parameter int Y_MIN           = 2,
  parameter int Y_MAX           = 11,
  parameter int START_X         = 1,
  parameter int START_Y         = 3,
  parameter int ATTACK_FRAMES   = 5,
  parameter int COOLDOWN_FRAMES = 3,
  parameter int ANIM_PERIOD     = 20,
  parameter int REPEAT_DELAY    = 4
) (
  input logic              clk,
  input logic              reset,
  player_ctrl_grid_if.slave io
);
  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_MOVE   = 2'b01,
    S_ATTACK = 2'b10,
    S_COOL   = 2'b11
  } state_e;

  localparam logic [COORD_W-1:0] XMIN = COORD_W'(X_MIN);
  localparam logic [COORD_W-1:0] XMAX = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] YMIN = COORD_W'(Y_MIN);
  localparam logic [COORD_W-1:0] YMAX = COORD_W'(Y_MAX);
  localparam logic [COORD_W-1:0] ONE  = COORD_W'(1);
  localparam logic [7:0] AF    = 8'(ATTACK_FRAMES);
  localparam logic [7:0] CF    = 8'(COOLDOWN_FRAMES);
  localparam logic [7:0] AP    = 8'(ANIM_PERIOD);
  localparam logic [7:0] AHALF = 8'(ANIM_PERIOD / 2);

  state_e             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] sx_q, sx_d, sy_q, sy_d;
  logic [1:0]         dir_q, dir_d, sdir_q, sdir_d;
  logic               orient_q, orient_d, svis_q, svis_d;
  logic [3:0]         sprite_q, sprite_d;
  logic [7:0]         atk_q, atk_d, cd_q, cd_d, anim_q, anim_d;
  logic               atk_prev_q, atk_prev_d;

  logic               press, atk_trig, step_ok, adj_ok;
  logic [1:0]         dsel;
  logic [COORD_W-1:0] adj_x, adj_y;
  logic [7:0]         anim_nxt;

  assign press = io.btn_up | io.btn_down | io.btn_left | io.btn_right;
  // Edge detect on ticks: a held button never re-arms the attack.
  assign atk_trig = io.btn_attack & ~atk_prev_q;

  always_comb begin
    dsel = dir_q;
    if (io.btn_up)         dsel = 2'b00;
    else if (io.btn_down)  dsel = 2'b10;
    else if (io.btn_left)  dsel = 2'b11;
    else if (io.btn_right) dsel = 2'b01;
  end

  // Neighbour cell along dsel; bounds checked before the add/subtract.
  always_comb begin
    adj_x  = x_q;
    adj_y  = y_q;
    adj_ok = 1'b0;
    unique case (dsel)
      2'b00: if (y_q > YMIN) begin adj_y = y_q - ONE; adj_ok = 1'b1; end
      2'b01: if (x_q < XMAX) begin adj_x = x_q + ONE; adj_ok = 1'b1; end
      2'b10: if (y_q < YMAX) begin adj_y = y_q + ONE; adj_ok = 1'b1; end
      2'b11: if (x_q > XMIN) begin adj_x = x_q - ONE; adj_ok = 1'b1; end
    endcase
  end

`ifdef PLAYER_AUTOREPEAT_EN
  logic [7:0] hold_q, hold_d;
  logic [1:0] last_q, last_d;
  localparam logic [7:0] RD = 8'(REPEAT_DELAY);

  assign step_ok = (hold_q == 8'd0) || (dsel != last_q) || (hold_q > RD);

  always_comb begin
    hold_d = hold_q;
    last_d = last_q;
    if (io.frame_tick) begin
      last_d = dsel;
      if (!press)                                 hold_d = 8'd0;
      else if (dsel != last_q || hold_q == 8'd0)  hold_d = 8'd1;
      else if (hold_q <= RD)                      hold_d = hold_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_q <= 8'd0;
      last_q <= 2'b01;
    end else begin
      hold_q <= hold_d;
      last_q <= last_d;
    end
  end
`else
  assign step_ok = 1'b1;
`endif

  assign anim_nxt = anim_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    sx_d       = sx_q;
    sy_d       = sy_q;
    dir_d      = dir_q;
    sdir_d     = sdir_q;
    orient_d   = orient_q;
    svis_d     = svis_q;
    sprite_d   = sprite_q;
    atk_d      = atk_q;
    cd_d       = cd_q;
    anim_d     = anim_q;
    atk_prev_d = atk_prev_q;
    if (io.frame_tick) begin
      atk_prev_d = io.btn_attack;
      if (anim_nxt == AP) begin
        anim_d   = 8'd0;
        sprite_d = 4'b0011;
      end else begin
        anim_d = anim_nxt;
        if (anim_nxt == AHALF) sprite_d = 4'b0010;
      end
      unique case (state_q)
        S_IDLE, S_MOVE: begin
          if (atk_trig) begin
            state_d = S_ATTACK;
            dir_d   = dsel;
            sdir_d  = dsel;
            if (press && dsel[0]) orient_d = dsel[1];
            sx_d    = adj_x;
            sy_d    = adj_y;
            svis_d  = adj_ok;
            atk_d   = 8'd1;
          end else if (press) begin
            state_d = S_MOVE;
            dir_d   = dsel;
            if (dsel[0]) orient_d = dsel[1];
            if (adj_ok && step_ok) begin
              x_d = adj_x;
              y_d = adj_y;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ATTACK: begin
          if (atk_q >= AF) begin
            svis_d  = 1'b0;
            cd_d    = 8'd1;
            state_d = (CF == 8'd0) ? S_IDLE : S_COOL;
          end else begin
            atk_d = atk_q + 8'd1;
          end
        end
        S_COOL: begin
          if (press) begin
            dir_d = dsel;
            if (dsel[0]) orient_d = dsel[1];
            if (adj_ok && step_ok) begin
              x_d = adj_x;
              y_d = adj_y;
            end
          end
          if (cd_q >= CF) state_d = S_IDLE;
          else            cd_d    = cd_q + 8'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      x_q        <= COORD_W'(START_X);
      y_q        <= COORD_W'(START_Y);
      sx_q       <= '0;
      sy_q       <= '0;
      dir_q      <= 2'b01;
      sdir_q     <= 2'b01;
      orient_q   <= 1'b0;
      svis_q     <= 1'b0;
      sprite_q   <= 4'b0011;
      atk_q      <= 8'd0;
      cd_q       <= 8'd0;
      anim_q     <= 8'd0;
      atk_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      dir_q      <= dir_d;
      sdir_q     <= sdir_d;
      orient_q   <= orient_d;
      svis_q     <= svis_d;
      sprite_q   <= sprite_d;
      atk_q      <= atk_d;
      cd_q       <= cd_d;
      anim_q     <= anim_d;
      atk_prev_q <= atk_prev_d;
    end
  end

  assign io.player_x      = x_q;
  assign io.player_y      = y_q;
  assign io.player_dir    = dir_q;
  assign io.player_orient = orient_q;
  assign io.player_sprite = sprite_q;
  assign io.sword_x       = sx_q;
  assign io.sword_y       = sy_q;
  assign io.sword_visible = svis_q;
  assign io.sword_dir     = sdir_q;
  assign io.state         = state_q;
endmodule

// File: tb/tb_player_ctrl_grid.sv
// Directed bench for player_ctrl_grid with default parameters.
// Drives ticks/buttons on negedges, checks registered outputs after each tick.
module tb_player_ctrl_grid;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_chk = 0;
  int n_fail = 0;

  player_ctrl_grid_if #(.COORD_W(4)) bus ();

  player_ctrl_grid dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic btns(input logic u, d, l, r, a);
    bus.btn_up     = u;
    bus.btn_down   = d;
    bus.btn_left   = l;
    bus.btn_right  = r;
    bus.btn_attack = a;
  endtask

  task automatic tick();
    @(negedge clk);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic chk_pos(input string tag, input int x, input int y);
    check({tag, ".x"}, int'(bus.player_x), x);
    check({tag, ".y"}, int'(bus.player_y), y);
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    btns(0, 0, 0, 0, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_pos("rst", 1, 3);
    check("rst.dir", int'(bus.player_dir), 1);
    check("rst.orient", int'(bus.player_orient), 0);
    check("rst.sprite", int'(bus.player_sprite), 3);
    check("rst.svis", int'(bus.sword_visible), 0);
    check("rst.sdir", int'(bus.sword_dir), 1);
    check("rst.state", int'(bus.state), 0);

    // No tick: everything holds.
    repeat (3) @(negedge clk);
    check("hold.sprite", int'(bus.player_sprite), 3);

    // Animation: sprite flips at tick 10, back at tick 20.
    repeat (9) tick();
    check("anim9", int'(bus.player_sprite), 3);
    tick();
    check("anim10", int'(bus.player_sprite), 2);
    repeat (9) tick();
    check("anim19", int'(bus.player_sprite), 2);
    tick();
    check("anim20", int'(bus.player_sprite), 3);
    check("idle.state", int'(bus.state), 0);

    // Up held 3 ticks, plus left also pressed: up has priority.
    btns(1, 0, 1, 0, 0);
    tick();
    chk_pos("up1", 1, 2);
    check("up1.dir", int'(bus.player_dir), 0);
    check("up1.state", int'(bus.state), 1);
    btns(1, 0, 0, 0, 0);
    tick();
    chk_pos("up2", 1, 2);
    tick();
    chk_pos("up3", 1, 2);
    check("up3.dir", int'(bus.player_dir), 0);
    btns(0, 0, 0, 0, 0);
    tick();
    check("rel.state", int'(bus.state), 0);

    // Left to x=0, then blocked.
    btns(0, 0, 1, 0, 0);
    tick();
    chk_pos("l1", 0, 2);
    tick();
    chk_pos("l2", 0, 2);
    check("l2.dir", int'(bus.player_dir), 3);
    check("l2.orient", int'(bus.player_orient), 1);
    btns(0, 0, 0, 0, 0);
    tick();

    // Attack facing left at x=0: sword hidden, timer still runs.
    btns(0, 0, 0, 0, 1);
    tick();
    btns(0, 0, 0, 0, 0);
    check("atkl1.state", int'(bus.state), 2);
    check("atkl1.svis", int'(bus.sword_visible), 0);
    for (int i = 2; i <= 5; i++) begin
      tick();
      check($sformatf("atkl%0d.state", i), int'(bus.state), 2);
    end
    tick();
    check("atkl6.state", int'(bus.state), 3);
    repeat (2) tick();
    check("atkl8.state", int'(bus.state), 3);
    tick();
    check("atkl9.state", int'(bus.state), 0);

    // Walk to (4,5) ending facing right.
    btns(0, 1, 0, 0, 0);
    repeat (3) tick();
    chk_pos("down3", 0, 5);
    check("down3.dir", int'(bus.player_dir), 2);
    btns(0, 0, 0, 1, 0);
    repeat (4) tick();
    chk_pos("right4", 4, 5);
    check("right4.orient", int'(bus.player_orient), 0);
    btns(0, 0, 0, 0, 0);
    tick();

    // Attack right: sword at (5,5) for 5 ticks, position locked.
    btns(0, 0, 0, 0, 1);
    tick();
    check("atk1.sx", int'(bus.sword_x), 5);
    check("atk1.sy", int'(bus.sword_y), 5);
    check("atk1.sdir", int'(bus.sword_dir), 1);
    check("atk1.svis", int'(bus.sword_visible), 1);
    check("atk1.state", int'(bus.state), 2);
    btns(0, 1, 0, 0, 0);
    for (int i = 2; i <= 5; i++) begin
      tick();
      check($sformatf("atk%0d.svis", i), int'(bus.sword_visible), 1);
      check($sformatf("atk%0d.state", i), int'(bus.state), 2);
    end
    chk_pos("atk5", 4, 5);
    check("atk5.sx", int'(bus.sword_x), 5);
    btns(0, 0, 0, 0, 0);
    tick();
    check("atk6.svis", int'(bus.sword_visible), 0);
    check("atk6.state", int'(bus.state), 3);
    btns(0, 0, 0, 0, 1);
    tick();
    check("cd2.state", int'(bus.state), 3);
    check("cd2.svis", int'(bus.sword_visible), 0);
    btns(1, 0, 0, 0, 0);
    tick();
    check("cd3.state", int'(bus.state), 3);
    chk_pos("cd3", 4, 4);
    btns(0, 0, 0, 0, 0);
    tick();
    check("cd4.state", int'(bus.state), 0);

    // Reset on tick 2 of an attack.
    btns(0, 0, 0, 0, 1);
    tick();
    check("ra1.state", int'(bus.state), 2);
    btns(0, 0, 0, 0, 0);
    tick();
    check("ra2.svis", int'(bus.sword_visible), 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("ra.svis", int'(bus.sword_visible), 0);
    check("ra.state", int'(bus.state), 0);
    chk_pos("ra", 1, 3);
    check("ra.dir", int'(bus.player_dir), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/player_ctrl_grid.md
Name: player_ctrl_grid

Overview:
Parametrised successor of the player movement/attack controller. Single clock domain: all state advances on `clk` edges qualified by a one-cycle `frame_tick` strobe, so no derived clocks are used. Tracks player grid position, facing, walk animation and a timed sword attack with cooldown. Feeds the renderer and the central collision/lives controller.

Parameters:
- COORD_W, 4, bit width of each of the x and y coordinates.
- X_MIN, 0, leftmost legal player column.
- X_MAX, 15, rightmost legal player column.
- Y_MIN, 2, top legal player row.
- Y_MAX, 11, bottom legal player row.
- START_X, 1, x coordinate after reset.
- START_Y, 3, y coordinate after reset.
- ATTACK_FRAMES, 5, frame ticks the sword stays out (at least 1).
- COOLDOWN_FRAMES, 3, frame ticks after an attack before attack is accepted again (0 allowed).
- ANIM_PERIOD, 20, frame ticks per walk-animation cycle; sprite toggles at ANIM_PERIOD/2.
- REPEAT_DELAY, 4, frame ticks of hold before auto-repeat (used only with the optional feature).

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous, active-low.
- frame_tick, in, 1, one-cycle strobe, once per video frame.
- btn_up / btn_down / btn_left / btn_right, in, 1 each, direction buttons, level.
- btn_attack, in, 1, attack button, level.
- player_x / player_y, out, COORD_W each, player position.
- player_dir, out, 2, facing: 00 up, 01 right, 10 down, 11 left.
- player_orient, out, 1, sprite mirror: 0 right, 1 left.
- player_sprite, out, 4, sprite index: 0011 or 0010.
- sword_x / sword_y, out, COORD_W each, sword cell.
- sword_visible, out, 1, sword drawn and active for collision.
- sword_dir, out, 2, sword orientation (same encoding as player_dir).
- state, out, 2, 00 IDLE, 01 MOVE, 10 ATTACK, 11 COOLDOWN.

Behaviour:
- Reset values (when `reset`=0 at a clk edge):
  - player_x=START_X, player_y=START_Y, player_dir=01, player_orient=0, player_sprite=0011.
  - sword_x=0, sword_y=0, sword_visible=0, sword_dir=01, state=IDLE.
  - All counters are cleared.
- Reset mid-attack aborts immediately; there is no residual sword.
- All outputs are registered. Inputs are sampled only on edges where frame_tick=1. Results appear the cycle after that edge. With frame_tick=0 every register holds.
- Direction select: if several direction buttons are pressed, priority is up > down > left > right. Exactly one step per move; no diagonals.
- IDLE on a tick:
  - attack pressed and cooldown done -> ATTACK. The sword appears on the same update.
  - otherwise, any direction pressed -> MOVE: apply the step now and set player_dir.
  - otherwise stay in IDLE.
- MOVE:
  - The step is applied only if the target stays within [X_MIN..X_MAX] x [Y_MIN..Y_MAX]. A blocked step still updates player_dir.
  - left/right also update player_orient.
  - Next tick: evaluate exactly as IDLE (attack has priority). With no input, return to IDLE.
  - Holding a direction moves one cell per tick.
- ATTACK:
  - On entry, any pressed direction overrides player_dir first. The sword is then placed in the adjacent cell along player_dir.
  - sword_dir follows player_dir; sword_visible=1.
  - If the adjacent cell is outside the legal range, sword_visible=0. The attack timer still runs.
  - The sword position is frozen for the attack; position is locked (no movement).
  - After ATTACK_FRAMES ticks including the entry tick: sword_visible=0, go to COOLDOWN, or to IDLE if COOLDOWN_FRAMES=0.
- COOLDOWN: movement is allowed (steps as in MOVE, state stays COOLDOWN). Attack is ignored. After COOLDOWN_FRAMES ticks -> IDLE.
- Holding attack: no re-trigger until the button is released and pressed again. Release must be seen on one tick.
- Animation: counter increments every tick. At ANIM_PERIOD/2 the sprite becomes 0010. At ANIM_PERIOD the counter wraps to 0 and the sprite becomes 0011.
- Arithmetic: bounds are checked before the add/subtract, so coordinates never wrap.

Optional Feature:
- Macro PLAYER_AUTOREPEAT_EN.
- Defined: a held direction steps on its first tick, then waits REPEAT_DELAY ticks, then steps every tick. The hold counter resets when the button is released or the direction changes.
- Undefined: step on every tick while held; REPEAT_DELAY is ignored.

Test Plan:
- Reset low for 2 clk, release -> player (1,3), dir 01, sprite 0011, sword_visible 0, state 00.
- Hold btn_up for 3 ticks from (1,3) -> y=2 after tick 1, stays 2 (Y_MIN); dir 00 throughout.
- Press btn_left at x=0 -> x stays 0, dir 11, orient 1.
- btn_attack for one tick facing right at (4,5) -> sword (5,5), dir 01, visible for exactly 5 ticks; then COOLDOWN for 3 ticks; an attack press during COOLDOWN is ignored.
- Attack while facing left at x=0 -> sword_visible 0, state ATTACK for 5 ticks.
- Assert reset on tick 2 of an attack -> next cycle sword_visible 0, state IDLE, player at (1,3).
